ascii_case_stream: RTL

//  Streaming, multi-lane ASCII case converter; successor to the single-byte combinational upper-caser.
//  - Converts LANES bytes per beat in one of four modes (pass, upper, lower, toggle).
//  - Buffers converted beats in a FIFO_DEPTH-entry FIFO between valid/ready interfaces.
//  - Sits between the byte-stream source and any downstream text consumer.

---
 rtl/ascii_case_stream.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ascii_case_stream.sv
// Streaming multi-lane ASCII case converter feeding a FIFO_DEPTH-beat output FIFO.
// Optional macro ASCII_CASE_STATS_EN adds a saturating conv_count of changed bytes.

module ascii_case_lane (
  input  logic [1:0] mode,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       changed
);
  logic is_up, is_lo;

  assign is_up = (din >= 8'd65) && (din <= 8'd90);
  assign is_lo = (din >= 8'd97) && (din <= 8'd122);

  always_comb begin
    dout = din;
    case (mode)
      2'd1: if (is_lo) dout = din - 8'd32;
      2'd2: if (is_up) dout = din + 8'd32;
      2'd3: begin
        if (is_up) dout = din + 8'd32;
        else if (is_lo) dout = din - 8'd32;
      end
      default: dout = din;
    endcase
    changed = (dout != din);
  end
endmodule

module ascii_case_stream #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*LANES-1:0]            in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8*LANES-1:0]            out_data,
`ifdef ASCII_CASE_STATS_EN
  output logic [15:0]                   conv_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(LANES + 1);

  logic [LANES-1:0][7:0]                 conv_data;
  logic [LANES-1:0]                      lane_chg;
  logic [FIFO_DEPTH-1:0][8*LANES-1:0]    mem;
  logic [AW-1:0]                         wr_ptr, rd_ptr;
  logic [LW-1:0]                         level_nxt;
  logic                                  push, pop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ascii_case_lane u_lane (
      .mode    (mode),
      .din     (in_data[8*i +: 8]),
      .dout    (conv_data[i]),
      .changed (lane_chg[i])
    );
  end

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // in_ready is a register so it stays low through reset and for one edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      in_ready <= (level_nxt < LW'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset; out_data is gated by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= conv_data;
  end

`ifdef ASCII_CASE_STATS_EN
  logic [CW-1:0] nchg;
  logic [16:0]   cnt_sum;

  always_comb begin
    nchg = '0;
    for (int i = 0; i < LANES; i++) nchg = nchg + CW'(lane_chg[i]);
  end

  assign cnt_sum = {1'b0, conv_count} + 17'(nchg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       conv_count <= '0;
    else if (push) conv_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`else
  logic unused_chg;
  assign unused_chg = ^{lane_chg, CW'(0)};
`endif
endmodule
